// File: rtl/pow_pkg.sv
// Shared types and constants for the sequential power unit.
package pow_pkg;

  localparam int unsigned BaseWDef = 4;
  localparam int unsigned ExpWDef  = 4;
  localparam int unsigned ResWDef  = 32;

  // Edges from accepted start to done: one ACC plus one SQ per exponent bit, minus the last SQ,
  // plus FIN.
  localparam int unsigned Latency = 2 * ExpWDef;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StSq,
    StFin
  } pow_state_e;

endpackage

// File: rtl/pow_mul.sv
// Combinational unsigned RES_W x RES_W multiplier with full-width product.
module pow_mul
  import pow_pkg::*;
#(
  parameter int unsigned RES_W = ResWDef
) (
  input  logic [RES_W-1:0]   a_i,
  input  logic [RES_W-1:0]   b_i,
  output logic [2*RES_W-1:0] p_o
);

  // Operands are widened first so the product keeps all 2*RES_W bits.
  assign p_o = {{RES_W{1'b0}}, a_i} * {{RES_W{1'b0}}, b_i};

endmodule

// File: rtl/pow_seq_ctrl.sv
// Right-to-left square-and-multiply power unit with start/busy/done handshake.
module pow_seq_ctrl
  import pow_pkg::*;
#(
  parameter int unsigned BASE_W = BaseWDef,
  parameter int unsigned EXP_W  = ExpWDef,
  parameter int unsigned RES_W  = ResWDef
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [BASE_W-1:0] base,
  input  logic [EXP_W-1:0]  exp,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic              overflow
);

  localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  pow_state_e       state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] sq_q, sq_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             sq_ovf_q, sq_ovf_d;
  logic             ovf_q, ovf_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [RES_W-1:0]   mul_a;
  logic [2*RES_W-1:0] prod;
  logic [RES_W-1:0]   prod_lo;
  logic               prod_hi_nz;

  // One multiplier: ACC multiplies acc by sq, SQ squares sq.
  assign mul_a      = (state_q == StAcc) ? acc_q : sq_q;
  assign prod_lo    = prod[RES_W-1:0];
  assign prod_hi_nz = |prod[2*RES_W-1:RES_W];

  pow_mul #(
    .RES_W(RES_W)
  ) u_mul (
    .a_i(mul_a),
    .b_i(sq_q),
    .p_o(prod)
  );

  // Next-state and datapath updates for the square-and-multiply sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sq_d       = sq_q;
    e_d        = e_q;
    idx_d      = idx_q;
    sq_ovf_d   = sq_ovf_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = RES_W'(1);
          sq_d     = RES_W'(base);
          e_d      = exp;
          idx_d    = '0;
          sq_ovf_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        if (e_q[idx_q]) begin
          acc_d = prod_lo;
          ovf_d = ovf_q | prod_hi_nz | sq_ovf_q;
        end
        state_d = (idx_q == IdxW'(EXP_W - 1)) ? StFin : StSq;
      end
      StSq: begin
        sq_d     = prod_lo;
        sq_ovf_d = sq_ovf_q | prod_hi_nz;
        idx_d    = idx_q + IdxW'(1);
        state_d  = StAcc;
      end
      StFin: begin
        result_d   = acc_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      sq_q       <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      sq_ovf_q   <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sq_q       <= sq_d;
      e_q        <= e_d;
      idx_q      <= idx_d;
      sq_ovf_q   <= sq_ovf_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pow_seq_ctrl.sv
// Directed, table-driven bench for pow_seq_ctrl.
module tb_pow_seq_ctrl;
  import pow_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [3:0]  base_in;
  logic [3:0]  exp_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  b;
    logic [3:0]  e;
    logic [31:0] res;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[9];

  pow_seq_ctrl #(
    .BASE_W(4),
    .EXP_W (4),
    .RES_W (32)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .base    (base_in),
    .exp     (exp_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Present operands, let the next edge accept them; returns 1ns after that edge.
  task automatic launch(input logic [3:0] b, input logic [3:0] e);
    start   = 1'b1;
    base_in = b;
    exp_in  = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done; 'used' edges since acceptance have already been consumed.
  task automatic wait_check(input string name, input int used, input logic [31:0] res,
                            input logic ovf);
    int n;
    bit seen;
    seen = 1'b0;
    n    = used;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, " done seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, " latency"}, 64'(n), 64'(Latency));
      chk({name, " result"}, 64'(result), 64'(res));
      chk({name, " overflow"}, 64'(overflow), 64'(ovf));
      chk({name, " busy low at done"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{4'd2,  4'd10, 32'd1024,       1'b0, "2^10"};
    vecs[1] = '{4'd3,  4'd15, 32'd14348907,   1'b0, "3^15"};
    vecs[2] = '{4'd15, 4'd8,  32'd2562890625, 1'b0, "15^8"};
    vecs[3] = '{4'd15, 4'd9,  32'd4083621007, 1'b1, "15^9"};
    vecs[4] = '{4'd2,  4'd3,  32'd8,          1'b0, "2^3"};
    vecs[5] = '{4'd0,  4'd0,  32'd1,          1'b0, "0^0"};
    vecs[6] = '{4'd0,  4'd5,  32'd0,          1'b0, "0^5"};
    vecs[7] = '{4'd1,  4'd15, 32'd1,          1'b0, "1^15"};
    vecs[8] = '{4'd7,  4'd0,  32'd1,          1'b0, "7^0"};

    start   = 1'b0;
    base_in = '0;
    exp_in  = '0;
    resetn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].b, vecs[i].e);
      chk({vecs[i].name, " busy after start"}, 64'(busy), 64'd1);
      wait_check(vecs[i].name, 0, vecs[i].res, vecs[i].ovf);
      @(posedge clk);
      #1;
      chk({vecs[i].name, " done one cycle"}, 64'(done), 64'd0);
    end

    // Start while busy is ignored; operand changes have no effect.
    launch(4'd3, 4'd15);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start   = 1'b1;
    base_in = 4'd7;
    exp_in  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_check("ignored start", 3, 32'd14348907, 1'b0);

    // Start held during the done cycle is accepted with no bubble.
    launch(4'd15, 4'd9);
    wait_check("b2b first", 0, 32'd4083621007, 1'b1);
    launch(4'd2, 4'd10);
    chk("b2b busy", 64'(busy), 64'd1);
    wait_check("b2b second", 0, 32'd1024, 1'b0);

    // Asynchronous reset mid-operation.
    launch(4'd15, 4'd9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("no done after abort", 64'(cnt), 64'd0);
    launch(4'd5, 4'd3);
    wait_check("5^3 after reset", 0, 32'd125, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
